pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Program counter register and instruction fetch stage, directly downstream of the PC-source mux (mux_PCSrc).
- Each cycle it takes the mux output (saida_pc) as the next PC. It also feeds pc4 back to the mux and to the branch adder.
- Drives a single-outstanding request/ready interface to instruction memory.
- Presents the fetched instruction to decode through a valid/accept handshake.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, width of PC, pc4, saida_pc and imem_addr.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- reset  input  1  synchronous, active-high reset.
- saida_pc  input  ADDR_W  next PC selected by mux_PCSrc.
- redirect  input  1  branch/jump taken: abandon current fetch and load saida_pc.
- stall  input  1  hazard stall from control: freeze PC and handshake.
- imem_req  output  1  instruction memory request.
- imem_addr  output  ADDR_W  fetch address, always equal to pc.
- imem_ready  input  1  memory response valid, sampled only while imem_req=1.
- imem_data  input  32  instruction word, valid when imem_req and imem_ready are both 1.
- pc  output  ADDR_W  current PC register.
- pc4  output  ADDR_W  pc+4, combinational.
- instr  output  32  captured instruction.
- instr_valid  output  1  instr holds a valid instruction for decode.
- instr_accept  input  1  decode consumes instr.
- fetch_count  output  32  number of instructions accepted by decode.

Behaviour:
- Reset (synchronous, active-high; highest priority):
  - pc=RESET_PC, state=S_REQ, instr=0, instr_valid=0, fetch_count=0.
  - Reset asserted mid-fetch: any in-flight response is dropped; no output change other than the reset values.
- pc4 = pc + 4, truncated to ADDR_W. 32'hFFFF_FFFC wraps to 0.
- imem_addr = pc, combinational.
- FSM, two states:
  - S_REQ:
    - imem_req = !stall. instr_valid=0.
    - If imem_req=1 and imem_ready=1: instr <= imem_data, go to S_OUT.
    - If stall=1 or imem_ready=0: stay in S_REQ, pc unchanged.
  - S_OUT:
    - imem_req=0. instr_valid=1.
    - If instr_accept=1 and stall=0: pc <= saida_pc, fetch_count <= fetch_count+1 (wraps at 2^32), go to S_REQ.
    - Otherwise: hold instr, pc and state.
- Timing and throughput:
  - Zero-wait memory gives 2 cycles per instruction.
  - First instr_valid appears 1 cycle after reset is released.
- Redirect (priority below reset, above everything else):
  - Any state: pc <= saida_pc, state <= S_REQ, instr_valid <= 0 next cycle.
  - In S_REQ with imem_ready=1 in the same cycle: imem_data is discarded and instr is not updated.
  - In S_OUT with instr_accept=1 in the same cycle: the accept still counts (fetch_count increments). pc takes saida_pc once only.
  - Redirect together with stall: redirect wins.
- Address changes only on state transitions or redirect. imem_addr is stable while imem_req=1 and no redirect/reset occurs.
- No combinational path from instr_accept to imem_req.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- When defined:
  - Adds output misaligned (1 bit, reset 0).
  - In S_REQ with pc[1:0]!=0: no memory request is issued. Next cycle instr=32'h0000_0000 (NOP), instr_valid=1, misaligned=1, state=S_OUT.
  - misaligned clears on leaving S_OUT, on redirect and on reset.
- When undefined:
  - Port is absent; pc[1:0] is passed to imem_addr unchecked.

Test Plan:
- Reset, then hold imem_ready=1, instr_accept=1, saida_pc=pc4, mem returns addr^32'hA5A5_0000:
  - instr_valid pulses every 2nd cycle.
  - pc goes 0, 4, 8, 12.
  - fetch_count=4 after 8 cycles.
- Hold imem_ready=0 for 3 cycles at pc=8:
  - imem_req=1 and imem_addr=8 stay stable.
  - instr_valid=0 throughout.
  - Fetch completes 1 cycle after imem_ready rises.
- In S_OUT at pc=12, hold instr_accept=0 for 2 cycles, then stall=1 with instr_accept=1:
  - instr is held; pc stays 12; fetch_count does not increment.
  - After stall drops, one accept increments it.
- In S_REQ at pc=16, assert redirect with saida_pc=32'h40 and imem_ready=1 in the same cycle:
  - Data is dropped; instr_valid=0.
  - Next request has imem_addr=32'h40.
- Assert reset while in S_OUT with fetch_count=5:
  - Next cycle pc=RESET_PC, instr_valid=0, fetch_count=0, state=S_REQ.
- With PC_ALIGN_CHECK_EN, redirect to saida_pc=32'h42:
  - No imem_req.
  - Next cycle instr=0, instr_valid=1, misaligned=1.
- Wrap case: at pc=32'hFFFF_FFFC, pc4=0; after accept with saida_pc=pc4, pc=0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// PC register plus single-outstanding instruction fetch with valid/accept hand-off to decode.
// Optional PC_ALIGN_CHECK_EN: misaligned PCs skip memory and deliver a NOP flagged by `misaligned`.
module pc_fetch_unit #(
    parameter int                 ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] saida_pc,
    input  logic              redirect,
    input  logic              stall,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_data,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc4,
    output logic [31:0]       instr,
    output logic              instr_valid,
    input  logic              instr_accept,
`ifdef PC_ALIGN_CHECK_EN
    output logic              misaligned,
`endif
    output logic [31:0]       fetch_count
);

    typedef enum logic {S_REQ, S_OUT} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc_nxt;
    logic [31:0]       instr_nxt;
    logic [31:0]       count_nxt;
    logic              accept_fire;
    logic              pc_bad;
    logic              align_nop;

`ifdef PC_ALIGN_CHECK_EN
    assign pc_bad = (pc[1:0] != 2'b00);
`else
    assign pc_bad = 1'b0;
`endif

    assign pc4       = pc + ADDR_W'(4);
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            instr       <= 32'h0;
            fetch_count <= 32'h0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            instr       <= instr_nxt;
            fetch_count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        instr_nxt   = instr;
        count_nxt   = fetch_count;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        accept_fire = 1'b0;
        align_nop   = 1'b0;

        case (state)
            S_REQ: imem_req    = !stall && !pc_bad;
            S_OUT: instr_valid = 1'b1;
            default: ;
        endcase

        // A stalled accept is not a consumption; a redirecting one still is.
        accept_fire = (state == S_OUT) && instr_accept && !stall;
        if (accept_fire)
            count_nxt = fetch_count + 32'd1;

        if (redirect) begin
            pc_nxt    = saida_pc;
            state_nxt = S_REQ;
        end else begin
            case (state)
                S_REQ: begin
                    if (pc_bad && !stall) begin
                        align_nop = 1'b1;
                        instr_nxt = 32'h0;
                        state_nxt = S_OUT;
                    end else if (imem_req && imem_ready) begin
                        instr_nxt = imem_data;
                        state_nxt = S_OUT;
                    end
                end
                S_OUT: begin
                    if (accept_fire) begin
                        pc_nxt    = saida_pc;
                        state_nxt = S_REQ;
                    end
                end
                default: state_nxt = S_REQ;
            endcase
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset || redirect)
            misaligned <= 1'b0;
        else if (align_nop)
            misaligned <= 1'b1;
        else if (accept_fire)
            misaligned <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed vector table, corner sequences, then random traffic vs a transaction model.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] saida_pc;
    logic        redirect, stall, imem_req, imem_ready, instr_valid, instr_accept;
    logic [31:0] imem_addr, imem_data, pc, pc4, instr, fetch_count;
`ifdef PC_ALIGN_CHECK_EN
    logic        misaligned;
`endif

    always #5 clk = ~clk;

    // Memory returns a word derived from the address it is asked for.
    assign imem_data = imem_addr ^ 32'hA5A5_0000;

    pc_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .saida_pc(saida_pc), .redirect(redirect), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_data(imem_data),
        .pc(pc), .pc4(pc4), .instr(instr), .instr_valid(instr_valid), .instr_accept(instr_accept),
`ifdef PC_ALIGN_CHECK_EN
        .misaligned(misaligned),
`endif
        .fetch_count(fetch_count)
    );

    typedef struct {
        logic [5:0]  ctl;   // {rst, redirect, stall, ready, accept, saida=pc+4}
        logic [31:0] saida;
        logic [31:0] e_pc;
        logic        e_vld;
        logic        e_req;
        logic [31:0] e_cnt;
        logic [31:0] e_instr;
    } vec_t;

    vec_t tbl[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic v(input logic [5:0] ctl, input logic [31:0] sp, input logic [31:0] epc,
                     input logic evld, input logic ereq, input logic [31:0] ecnt, input logic [31:0] ein);
        vec_t t;
        t.ctl = ctl; t.saida = sp; t.e_pc = epc; t.e_vld = evld;
        t.e_req = ereq; t.e_cnt = ecnt; t.e_instr = ein;
        tbl.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic drive(input logic r, input logic rd, input logic st, input logic rdy,
                         input logic acc, input logic [31:0] sp);
        reset = r; redirect = rd; stall = st; imem_ready = rdy; instr_accept = acc; saida_pc = sp;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level reference: a held slot plus a fetch pointer.
    logic [31:0] m_pc, m_instr, m_cnt;
    logic        m_full;

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick(); tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        v(6'b000111, 0, 32'h0,  1'b0, 1'b1, 0, 32'h0);
        v(6'b000111, 0, 32'h0,  1'b1, 1'b0, 0, 32'hA5A5_0000);
        v(6'b000111, 0, 32'h4,  1'b0, 1'b1, 1, 32'hA5A5_0000);
        v(6'b000111, 0, 32'h4,  1'b1, 1'b0, 1, 32'hA5A5_0004);
        v(6'b000001, 0, 32'h8,  1'b0, 1'b1, 2, 32'hA5A5_0004);
        v(6'b000001, 0, 32'h8,  1'b0, 1'b1, 2, 32'hA5A5_0004);
        v(6'b000001, 0, 32'h8,  1'b0, 1'b1, 2, 32'hA5A5_0004);
        v(6'b000101, 0, 32'h8,  1'b0, 1'b1, 2, 32'hA5A5_0004);
        v(6'b000011, 0, 32'h8,  1'b1, 1'b0, 2, 32'hA5A5_0008);
        v(6'b000101, 0, 32'hC,  1'b0, 1'b1, 3, 32'hA5A5_0008);
        v(6'b000001, 0, 32'hC,  1'b1, 1'b0, 3, 32'hA5A5_000C);
        v(6'b000001, 0, 32'hC,  1'b1, 1'b0, 3, 32'hA5A5_000C);
        v(6'b001011, 0, 32'hC,  1'b1, 1'b0, 3, 32'hA5A5_000C);
        v(6'b000011, 0, 32'hC,  1'b1, 1'b0, 3, 32'hA5A5_000C);
        v(6'b010100, 32'h40, 32'h10, 1'b0, 1'b1, 4, 32'hA5A5_000C);
        v(6'b000101, 0, 32'h40, 1'b0, 1'b1, 4, 32'hA5A5_000C);
        v(6'b000011, 0, 32'h40, 1'b1, 1'b0, 4, 32'hA5A5_0040);
        v(6'b000101, 0, 32'h44, 1'b0, 1'b1, 5, 32'hA5A5_0040);
        v(6'b100001, 0, 32'h44, 1'b1, 1'b0, 5, 32'hA5A5_0044);
        v(6'b000001, 0, 32'h0,  1'b0, 1'b1, 0, 32'h0);
        v(6'b001101, 0, 32'h0,  1'b0, 1'b0, 0, 32'h0);
        v(6'b000101, 0, 32'h0,  1'b0, 1'b1, 0, 32'h0);

        foreach (tbl[i]) begin
            drive(tbl[i].ctl[5], tbl[i].ctl[4], tbl[i].ctl[3], tbl[i].ctl[2], tbl[i].ctl[1],
                  tbl[i].ctl[0] ? tbl[i].e_pc + 32'd4 : tbl[i].saida);
            #3;
            chk($sformatf("vec%0d pc", i),        pc,          tbl[i].e_pc);
            chk($sformatf("vec%0d addr", i),      imem_addr,   tbl[i].e_pc);
            chk($sformatf("vec%0d pc4", i),       pc4,         tbl[i].e_pc + 32'd4);
            chk($sformatf("vec%0d valid", i),     {31'b0, instr_valid}, {31'b0, tbl[i].e_vld});
            chk($sformatf("vec%0d req", i),       {31'b0, imem_req},    {31'b0, tbl[i].e_req});
            chk($sformatf("vec%0d count", i),     fetch_count, tbl[i].e_cnt);
            chk($sformatf("vec%0d instr", i),     instr,       tbl[i].e_instr);
            tick();
        end

        // Now in S_OUT at pc 0, count 0: redirect together with accept.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100);
        #3 chk("redir_acc valid_before", {31'b0, instr_valid}, 32'd1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        #3;
        chk("redir_acc pc", pc, 32'h100);
        chk("redir_acc count", fetch_count, 32'd1);
        chk("redir_acc valid", {31'b0, instr_valid}, 32'd0);
        tick();
        chk("redir_acc instr", instr, 32'hA5A5_0100);

        // Wrap of pc4 at the top of the address space.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        #3;
        chk("wrap pc", pc, 32'hFFFF_FFFC);
        chk("wrap pc4", pc4, 32'h0);
        chk("wrap count", fetch_count, 32'd1);
        tick();
        chk("wrap instr", instr, 32'h5A5A_FFFC);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        tick();
        chk("wrap pc_after", pc, 32'h0);
        chk("wrap count_after", fetch_count, 32'd2);

`ifdef PC_ALIGN_CHECK_EN
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h42);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        #3;
        chk("mis pc", pc, 32'h42);
        chk("mis req", {31'b0, imem_req}, 32'd0);
        chk("mis flag_before", {31'b0, misaligned}, 32'd0);
        tick();
        chk("mis instr", instr, 32'h0);
        chk("mis valid", {31'b0, instr_valid}, 32'd1);
        chk("mis flag", {31'b0, misaligned}, 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h48);
        tick();
        chk("mis flag_clear", {31'b0, misaligned}, 32'd0);
        chk("mis pc_next", pc, 32'h48);
        chk("mis req_next", {31'b0, imem_req}, 32'd1);
`endif

        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        m_pc = 32'h0; m_instr = 32'h0; m_cnt = 32'h0; m_full = 1'b0;

        for (int c = 0; c < 400; c++) begin
            logic r, rd, st, rdy, acc;
            logic [31:0] sp;
            r   = ($urandom % 50) == 0;
            rd  = ($urandom % 10) == 0;
            st  = ($urandom % 4) == 0;
            rdy = ($urandom % 10) < 6;
            acc = ($urandom % 10) < 6;
            sp  = (($urandom % 3) == 0) ? ($urandom & 32'hFFFF_FFFC) : m_pc + 32'd4;
            drive(r, rd, st, rdy, acc, sp);
            #3;
            chk("rnd pc", pc, m_pc);
            chk("rnd addr", imem_addr, m_pc);
            chk("rnd valid", {31'b0, instr_valid}, {31'b0, m_full});
            chk("rnd req", {31'b0, imem_req}, {31'b0, !m_full && !st});
            chk("rnd count", fetch_count, m_cnt);
            if (m_full) chk("rnd instr", instr, m_instr);

            if (r) begin
                m_pc = 32'h0; m_instr = 32'h0; m_cnt = 32'h0; m_full = 1'b0;
            end else begin
                if (m_full && acc && !st) m_cnt = m_cnt + 32'd1;
                if (rd) begin
                    m_pc = sp; m_full = 1'b0;
                end else if (!m_full && !st && rdy) begin
                    m_instr = m_pc ^ 32'hA5A5_0000; m_full = 1'b1;
                end else if (m_full && acc && !st) begin
                    m_pc = sp; m_full = 1'b0;
                end
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
